// File: rtl/cordic_rotator.sv
// Iterative CORDIC rotator: rotates (KINIT, 0) by the angle encoded in dir,
// one shift-add micro-rotation per clock, yielding cos/sin in signed fixed point.
module cordic_rotator #(
    parameter int W     = 16,
    parameter int N     = 6,
    parameter int KINIT = 4975
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic [N-1:0]        dir,
    output logic                busy,
    output logic                done,
    output logic signed [W-1:0] x_out,
    output logic signed [W-1:0] y_out
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_ITER = IW'(N - 1);
    localparam logic signed [W-1:0] X_INIT = W'(KINIT);

    typedef enum logic [1:0] {
        IDLE,
        ROT,
        DONE
    } state_t;

    state_t              stateReg, stateNext;
    logic [N-1:0]        dirReg;
    logic [IW-1:0]       iReg;
    logic signed [W-1:0] xReg, yReg;
    logic signed [W-1:0] xShift, yShift, xStep, yStep;
    logic                load, lastIter;

    assign lastIter = (iReg == LAST_ITER);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // A new request is accepted from IDLE and also from DONE, so a held
    // start gives back-to-back operations with one gap cycle each.
    always_comb begin
        stateNext = stateReg;
        load      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (stateReg)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    stateNext = ROT;
                end
            end
            ROT: begin
                busy = 1'b1;
                if (lastIter) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load      = 1'b1;
                    stateNext = ROT;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Arithmetic shifts floor toward -inf; sums wrap modulo 2^W.
    always_comb begin
        xShift = xReg >>> iReg;
        yShift = yReg >>> iReg;
        if (dirReg[iReg]) begin
            xStep = xReg - yShift;
            yStep = yReg + xShift;
        end else begin
            xStep = xReg + yShift;
            yStep = yReg - xShift;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            dirReg <= '0;
            iReg   <= '0;
            xReg   <= '0;
            yReg   <= '0;
            x_out  <= '0;
            y_out  <= '0;
        end else if (load) begin
            dirReg <= dir;
            iReg   <= '0;
            xReg   <= X_INIT;
            yReg   <= '0;
        end else if (stateReg == ROT) begin
            xReg <= xStep;
            yReg <= yStep;
            iReg <= iReg + 1'b1;
            if (lastIter) begin
                x_out <= xStep;
                y_out <= yStep;
            end
        end
    end

endmodule

// File: tb/tb_cordic_rotator.sv
// Self-checking bench for cordic_rotator: directed scenarios plus randomized
// direction vectors compared against an integer-arithmetic CORDIC model.
module tb_cordic_rotator;

    localparam int W     = 16;
    localparam int N     = 6;
    localparam int KINIT = 4975;

    logic                CLK = 1'b0;
    logic                RST;
    logic                start;
    logic [N-1:0]        dir;
    logic                busy;
    logic                done;
    logic signed [W-1:0] x_out;
    logic signed [W-1:0] y_out;

    int checks = 0;
    int errors = 0;

    cordic_rotator #(.W(W), .N(N), .KINIT(KINIT)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .start (start),
        .dir   (dir),
        .busy  (busy),
        .done  (done),
        .x_out (x_out),
        .y_out (y_out)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int wrapW(input int v);
        int m;
        m = v % (1 << W);
        if (m < 0) m += (1 << W);
        if (m >= (1 << (W - 1))) m -= (1 << W);
        return m;
    endfunction

    function automatic int floorDiv2(input int v, input int s);
        int p;
        p = 1 << s;
        if (v >= 0) return v / p;
        return -((-v + p - 1) / p);
    endfunction

    // Plain-math CORDIC: rotate (K,0) by +/- atan(2^-i) for each i.
    task automatic modelRot(input logic [N-1:0] d, input int iters,
                            output logic signed [W-1:0] xe, output logic signed [W-1:0] ye);
        int x, y, xn, yn;
        x = KINIT;
        y = 0;
        for (int i = 0; i < iters; i++) begin
            if (d[i]) begin
                xn = x - floorDiv2(y, i);
                yn = y + floorDiv2(x, i);
            end else begin
                xn = x + floorDiv2(y, i);
                yn = y - floorDiv2(x, i);
            end
            x = wrapW(xn);
            y = wrapW(yn);
        end
        xe = W'(x);
        ye = W'(y);
    endtask

    // Pulses start for one cycle, then waits (bounded) for done while
    // counting busy cycles and watching the outputs stay frozen.
    task automatic runOp(input logic [N-1:0] d, output int busyCycles, output logic gotDone,
                         output logic heldOk, output logic signed [W-1:0] xr,
                         output logic signed [W-1:0] yr);
        logic signed [W-1:0] xPrev, yPrev;
        busyCycles = 0;
        gotDone    = 1'b0;
        heldOk     = 1'b1;
        xPrev      = x_out;
        yPrev      = y_out;
        xr         = '0;
        yr         = '0;
        start      = 1'b1;
        dir        = d;
        tick();
        start = 1'b0;
        dir   = $urandom_range(0, (1 << N) - 1);
        for (int c = 0; c < 3 * N + 10; c++) begin
            if (done) begin
                gotDone = 1'b1;
                xr      = x_out;
                yr      = y_out;
                break;
            end
            if (busy) busyCycles++;
            if (x_out !== xPrev || y_out !== yPrev) heldOk = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        RST   = 1'b0;
        start = 1'b1;
        dir   = '1;
        tick();
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags busy/done=%b required 00", {busy, done});
        end
        checks++;
        if (x_out !== 0 || y_out !== 0) begin
            errors++;
            $display("FAIL reset_outputs got (%0d,%0d) required (0,0)", x_out, y_out);
        end
        start = 1'b0;
        #3 RST = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({busy, done} !== 2'b00) begin
                errors++;
                $display("FAIL reset_idle cycle %0d busy/done=%b required 00", c, {busy, done});
            end
        end
        $display("test_reset complete");
    endtask

    task automatic test_all_pos();
        int bc;
        logic gd, held;
        logic signed [W-1:0] xr, yr;
        runOp('1, bc, gd, held, xr, yr);
        checks++;
        if (!gd || xr !== -16'sd1151 || yr !== 16'sd8107) begin
            errors++;
            $display("FAIL all_pos done=%b got (%0d,%0d) required (-1151,8107)", gd, xr, yr);
        end
        checks++;
        if (bc != N) begin
            errors++;
            $display("FAIL all_pos_busy got %0d cycles required %0d", bc, N);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL all_pos_pulse done=%b required 0 one cycle after pulse", done);
        end
        $display("op dir=%b -> (%0d,%0d) busy=%0d", 6'b111111, xr, yr, bc);
    endtask

    task automatic test_all_neg();
        int c;
        logic gd;
        start = 1'b1;
        dir   = '0;
        tick();
        start = 1'b0;
        tick();
        tick();
        checks++;
        if (dut.xReg !== 16'sd2487) begin
            errors++;
            $display("FAIL neg_iter1_x got %0d required 2487", dut.xReg);
        end
        gd = 1'b0;
        for (c = 0; c < 20; c++) begin
            if (done) begin
                gd = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!gd || x_out !== -16'sd1155 || y_out !== -16'sd8106) begin
            errors++;
            $display("FAIL all_neg done=%b got (%0d,%0d) required (-1155,-8106)", gd, x_out, y_out);
        end
        $display("op dir=%b -> (%0d,%0d)", 6'b000000, x_out, y_out);
        tick();
    endtask

    task automatic test_start_ignored();
        logic [N-1:0] dA, dB;
        logic signed [W-1:0] xe, ye;
        int doneCount;
        logic signed [W-1:0] xr, yr;
        dA = N'($urandom_range(0, (1 << N) - 1));
        dB = ~dA;
        modelRot(dA, N, xe, ye);
        start = 1'b1;
        dir   = dA;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        dir   = dB;
        tick();
        tick();
        tick();
        start     = 1'b0;
        doneCount = 0;
        xr        = '0;
        yr        = '0;
        for (int c = 0; c < 15; c++) begin
            if (done) begin
                doneCount++;
                xr = x_out;
                yr = y_out;
            end
            tick();
        end
        checks++;
        if (doneCount != 1 || xr !== xe || yr !== ye) begin
            errors++;
            $display("FAIL start_ignored pulses=%0d got (%0d,%0d) required 1 pulse (%0d,%0d)",
                     doneCount, xr, yr, xe, ye);
        end
        $display("op dir=%b (late start dir=%b) -> (%0d,%0d)", dA, dB, xr, yr);
    endtask

    task automatic test_back_to_back();
        int lastDone, pulses;
        start    = 1'b1;
        dir      = '1;
        lastDone = -1;
        pulses   = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done) begin
                pulses++;
                checks++;
                if (x_out !== -16'sd1151 || y_out !== 16'sd8107) begin
                    errors++;
                    $display("FAIL b2b_value pulse %0d got (%0d,%0d) required (-1151,8107)",
                             pulses, x_out, y_out);
                end
                if (lastDone >= 0) begin
                    checks++;
                    if (c - lastDone != N + 1) begin
                        errors++;
                        $display("FAIL b2b_period got %0d cycles required %0d", c - lastDone, N + 1);
                    end
                end
                $display("b2b pulse %0d at cycle %0d -> (%0d,%0d)", pulses, c, x_out, y_out);
                lastDone = c;
            end
        end
        checks++;
        if (pulses < 5) begin
            errors++;
            $display("FAIL b2b_count got %0d pulses required >=5", pulses);
        end
        start = 1'b0;
        for (int c = 0; c < 10; c++) tick();
    endtask

    task automatic test_reset_abort();
        int bc, doneCount;
        logic gd, held;
        logic signed [W-1:0] xr, yr;
        start = 1'b1;
        dir   = '0;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        #2 RST = 1'b0;
        #1;
        checks++;
        if ({busy, done} !== 2'b00 || x_out !== 0 || y_out !== 0) begin
            errors++;
            $display("FAIL abort_clear busy/done=%b got (%0d,%0d) required 00 (0,0)",
                     {busy, done}, x_out, y_out);
        end
        tick();
        #2 RST = 1'b1;
        doneCount = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done || busy) doneCount++;
        end
        checks++;
        if (doneCount != 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d active cycles required 0", doneCount);
        end
        runOp('1, bc, gd, held, xr, yr);
        checks++;
        if (!gd || xr !== -16'sd1151 || yr !== 16'sd8107) begin
            errors++;
            $display("FAIL abort_restart done=%b got (%0d,%0d) required (-1151,8107)", gd, xr, yr);
        end
        $display("abort then op dir=%b -> (%0d,%0d)", 6'b111111, xr, yr);
        tick();
    endtask

    task automatic test_random();
        int bc;
        logic gd, held;
        logic [N-1:0] d;
        logic signed [W-1:0] xr, yr, xe, ye;
        for (int k = 0; k < 24; k++) begin
            d = N'($urandom_range(0, (1 << N) - 1));
            modelRot(d, N, xe, ye);
            runOp(d, bc, gd, held, xr, yr);
            checks++;
            if (!gd || xr !== xe || yr !== ye || bc != N || !held) begin
                errors++;
                $display("FAIL random_%0d dir=%b done=%b busy=%0d held=%b got (%0d,%0d) required (%0d,%0d) busy=%0d",
                         k, d, gd, bc, held, xr, yr, xe, ye, N);
            end
            $display("rand op %0d dir=%b -> (%0d,%0d) model (%0d,%0d)", k, d, xr, yr, xe, ye);
            for (int g = 0, gap = $urandom_range(1, 3); g < gap; g++) tick();
        end
    endtask

    initial begin
        start = 1'b0;
        dir   = '0;
        RST   = 1'b0;
        test_reset();
        test_all_pos();
        test_all_neg();
        test_start_ignored();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cordic_rotator.md
Name: cordic_rotator

Overview:
- Consumes the per-iteration rotation-direction vector produced by the CORDIC angle-decomposition control path.
- Runs iterative CORDIC shift-add rotations of the vector (K, 0) to produce cos/sin of the decomposed angle in signed fixed point.
- One iteration per clock; start/busy/done handshake toward the downstream display/consumer logic.

Parameters:
- W, 16, data width of x/y (signed, Q2.(W-3); default Q2.13)
- N, 6, iteration count; width of dir
- KINIT, 4975, initial x = CORDIC gain 0.60735 scaled by 2^13 (N=6)

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  reset; asynchronous, active-low
- start  input  1  request; sampled only in IDLE or DONE
- dir  input  N  direction bits; dir[i] applies to iteration i; 1 = positive rotation, 0 = negative
- busy  output  1  high in ROT
- done  output  1  one-cycle pulse when result valid
- x_out  output  W  signed cos result, held until next completion
- y_out  output  W  signed sin result, held until next completion

Behaviour:
- Reset (RST=0, async): state=IDLE, busy=0, done=0, x_out=0, y_out=0, iteration counter i=0, internal x/y=0, latched dir=0.
- States: IDLE, ROT, DONE.
- IDLE: start=1 at an edge -> latch dir, x<=KINIT, y<=0, i<=0, go to ROT.
- ROT, one iteration per edge, arithmetic right shift (>>>, floor toward -inf), results mod 2^W with no saturation:
  - dir[i]=1: x<=x-(y>>>i), y<=y+(x>>>i).
  - dir[i]=0: x<=x+(y>>>i), y<=y-(x>>>i).
  - Both updates use pre-edge x/y.
  - i<=i+1.
  - On the edge performing iteration N-1: x_out/y_out <= final values, done<=1, state<=DONE.
- Latency: start sampled at edge E -> done=1 and outputs valid in the cycle after edge E+N. busy=1 for exactly N cycles.
- DONE lasts one cycle; done=1 only here.
  - start=1 in DONE -> behaves as in IDLE (relatch, go to ROT). Back-to-back operations are supported with 1 idle cycle per op.
  - Otherwise -> IDLE.
- start in ROT is ignored; dir changes during ROT are ignored (latched copy used).
- x_out/y_out change only at completion, never mid-operation.
- RST asserted mid-operation aborts immediately to reset values. No done pulse occurs for the aborted operation.

Test Plan:
- Reset: hold RST=0 two cycles with start=1 -> busy=0, done=0, x_out=0, y_out=0; release and keep start=0 -> remains IDLE.
- dir=6'b111111, start one cycle -> busy high 6 cycles, then done pulse with x_out=-1151, y_out=8107 (~cos/sin 98.09°).
- dir=6'b000000 -> x_out=-1155, y_out=-8106 (checks floor shifts on negatives); intermediate x after iteration 1 = 2487.
- Pulse start again at cycles 2-4 of ROT with a different dir -> ignored; result matches the first dir only, single done pulse.
- Hold start=1 continuously with dir=6'b111111 -> done pulses every 7 cycles, each with (-1151, 8107).
- Assert RST at ROT iteration 3 -> outputs and state cleared asynchronously, no done. Restart with dir=6'b111111 -> correct (-1151, 8107).
